// File: rtl/jpeg_blk_ctrl.sv
// Sequencing controller for the 64-coefficient JPEG holding register: staging-buffer fill,
// latch pulse and valid/ready block delivery. Define JPEG_BLK_CTRL_ZIGZAG_EN for zig-zag slots.
module jpeg_blk_ctrl #(
    parameter int N_COEF = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              latch_en,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic [ADDR_W:0]   fill_cnt,
    output logic [15:0]       blk_cnt
);

    typedef enum logic [1:0] {StIdle, StFill, StXfer, StWait} state_e;

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(N_COEF - 1);

    state_e          state;
    logic [ADDR_W:0] cnt;
    logic            accept;
    logic            handshake;
    logic [ADDR_W-1:0] slot;

`ifdef JPEG_BLK_CTRL_ZIGZAG_EN
    localparam logic [5:0] ZIGZAG [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
    assign slot = ADDR_W'(ZIGZAG[cnt[5:0]]);
`else
    assign slot = cnt[ADDR_W-1:0];
`endif

    assign in_ready  = (state == StIdle) || (state == StFill);
    assign accept    = in_valid & in_ready;
    assign wr_en     = accept;
    // Address is only meaningful while accepting; hold it at 0 when the buffer is full.
    assign wr_addr   = in_ready ? slot : '0;
    assign latch_en  = (state == StXfer);
    assign handshake = blk_valid & blk_ready;
    assign fill_cnt  = cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            cnt       <= '0;
            blk_valid <= 1'b0;
            blk_cnt   <= '0;
        end else begin
            if (handshake) begin
                blk_valid <= 1'b0;
                blk_cnt   <= blk_cnt + 16'd1;
            end
            unique case (state)
                StIdle, StFill: begin
                    if (flush) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end else if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            // Latch straight away if the holding register is free or freed now.
                            state <= (!blk_valid || blk_ready) ? StXfer : StWait;
                        end else begin
                            state <= StFill;
                        end
                    end
                end
                StWait: begin
                    if (flush) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end else if (handshake) begin
                        state <= StXfer;
                    end
                end
                StXfer: begin
                    state     <= StIdle;
                    cnt       <= '0;
                    blk_valid <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
